// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: forwarding select encodings and the
// destination-tracking slot types used by the hazard/forwarding control.
package cpu_pkg;

  localparam int unsigned DEF_REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;  // register-file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB write-back data
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

  // Tracking slot for an in-flight instruction.
  typedef struct packed {
    logic [DEF_REG_AW-1:0] rd;
    logic                  we;
    logic                  mr;
  } slot_t;

  // Once past EX the load flag is no longer needed.
  typedef struct packed {
    logic [DEF_REG_AW-1:0] rd;
    logic                  we;
  } dst_t;

  // True when a stage will write a non-x0 register equal to rs.
  function automatic logic dst_hit(input dst_t d, input logic [DEF_REG_AW-1:0] rs);
    return d.we && (d.rd != '0) && (d.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU operand: MEM producer beats WB producer,
// x0 never forwards.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic [DEF_REG_AW-1:0] ex_rs_i,
  input  dst_t                  mem_i,
  input  dst_t                  wb_i,
  output logic [1:0]            sel_o
);

  // Youngest matching producer wins.
  always_comb begin
    sel_o = FWD_REG;
    if (dst_hit(mem_i, ex_rs_i)) begin
      sel_o = FWD_MEM;
    end else if (dst_hit(wb_i, ex_rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage pipeline.
// Tracks rd/we/load of instructions in EX, MEM and WB, generates operand
// forwarding selects, stalls on load-use, honours the data-cache freeze and
// counts load-use stall cycles (saturating).
// Optional: define FWD_WB_BYPASS_EN to add the ID write-through bypass
// outputs id_byp_a_o / id_byp_b_o.
module fwd_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW,  // must match the package slot width
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
`ifdef FWD_WB_BYPASS_EN
  output logic              id_byp_a_o,
  output logic              id_byp_b_o,
`endif
  output logic [CNT_W-1:0]  stall_cnt_o
);

  slot_t             ex_q,     ex_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  dst_t              mem_q,    mem_d;
  dst_t              wb_q,     wb_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              hazard;

  // Load in EX whose (non-x0) rd is read by the instruction in ID.
  always_comb begin
    hazard = ex_q.mr && (ex_q.rd != '0) &&
             ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
  end

  // Stall and write-enable outputs.
  always_comb begin
    stall_o      = hazard | mem_stall_i;
    pc_write_o   = ~stall_o;
    ifid_write_o = ~stall_o;
    stall_cnt_o  = cnt_q;
  end

  // Pipeline advance: freeze on cache stall, otherwise shift and fill EX.
  always_comb begin
    ex_d     = ex_q;
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    cnt_d    = cnt_q;
    if (!mem_stall_i) begin
      wb_d  = mem_q;
      mem_d = '{rd: ex_q.rd, we: ex_q.we};
      if (hazard || flush_i) begin
        ex_d     = '0;
        ex_rs1_d = '0;
        ex_rs2_d = '0;
      end else begin
        ex_d     = '{rd: id_rd_i, we: id_regwrite_i, mr: id_memread_i};
        ex_rs1_d = id_rs1_i;
        ex_rs2_d = id_rs2_i;
      end
      // A hazard coinciding with a flush still costs one counted cycle.
      if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Slot and counter state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      cnt_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      cnt_q    <= cnt_d;
    end
  end

  fwd_sel u_fwd_a (
    .ex_rs_i (ex_rs1_q),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .sel_o   (fwd_a_o)
  );

  fwd_sel u_fwd_b (
    .ex_rs_i (ex_rs2_q),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .sel_o   (fwd_b_o)
  );

`ifdef FWD_WB_BYPASS_EN
  // Write-through bypass from WB into the ID register read.
  always_comb begin
    id_byp_a_o = dst_hit(wb_q, id_rs1_i);
    id_byp_b_o = dst_hit(wb_q, id_rs2_i);
  end
`endif

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side counterpart of the 3:1 forwarding operand muxes in the pipelined CPU.
- Tracks destination register, write-enable and load flags of in-flight instructions through EX, MEM and WB.
- Generates the 2-bit forwarding selects for both ALU operands, detects load-use hazards and inserts bubbles.
- Honours the data-cache memory stall and keeps a saturating count of load-use stall cycles.

Parameters:
- REG_AW, 5, register index width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  input  1  core clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- id_rs1_i  input  REG_AW  rs1 of the instruction in ID.
- id_rs2_i  input  REG_AW  rs2 of the instruction in ID.
- id_rd_i  input  REG_AW  rd of the instruction in ID.
- id_regwrite_i  input  1  ID instruction writes rd.
- id_memread_i  input  1  ID instruction is a load.
- flush_i  input  1  discard the ID instruction (taken branch).
- mem_stall_i  input  1  data cache busy; freeze the whole pipeline.
- fwd_a_o  output  2  operand-A mux select.
- fwd_b_o  output  2  operand-B mux select.
- stall_o  output  1  pipeline stalled this cycle.
- pc_write_o  output  1  PC may update.
- ifid_write_o  output  1  IF/ID register may update.
- stall_cnt_o  output  CNT_W  load-use stall cycles since reset.

Behaviour:
- Internal state:
  - EX slot: rs1, rs2, rd, we, mr.
  - MEM slot: rd, we.
  - WB slot: rd, we.
  - Stall counter.
- Reset (rst_i=0, asynchronous): all slots and the counter clear to 0. Outputs then read fwd_a_o=fwd_b_o=2'b00, stall_o=0, pc_write_o=1, ifid_write_o=1, stall_cnt_o=0.
- Load-use hazard (combinational):
  - hazard = ex_mr and ex_rd!=0 and (ex_rd==id_rs1_i or ex_rd==id_rs2_i).
- Stall outputs (combinational):
  - stall_o = hazard or mem_stall_i.
  - pc_write_o = ifid_write_o = not stall_o.
- Per rising edge, in priority order:
  1. mem_stall_i=1: every slot and the counter hold.
  2. Otherwise WB<=MEM and MEM<=EX. EX then loads as follows:
     - hazard or flush_i: EX loads a bubble (all fields 0).
     - neither: EX loads the ID fields.
  3. Counter: +1 when hazard=1 and mem_stall_i=0; saturates at all-ones and never wraps.
- Forwarding select for operand A (combinational from the slots, zero latency):
  - 2'b10 if mem_we and mem_rd!=0 and mem_rd==ex_rs1 (EX/MEM ALU result).
  - else 2'b01 if wb_we and wb_rd!=0 and wb_rd==ex_rs1 (MEM/WB write-back data).
  - else 2'b00 (register-file value).
  - Operand B uses the same rule with ex_rs2.
  - Encoding 2'b11 is never produced.
- Boundary cases:
  - MEM and WB both match: MEM wins (youngest value).
  - x0 is never forwarded and never causes a hazard.
  - Hazard together with flush_i: a single bubble, counter still increments.
  - mem_stall_i during a hazard: hazard cycles are not counted while frozen. Forwarding selects stay stable because the slots hold.
  - Reset asserted mid-stall: clears immediately. The first edge after deassert behaves as a normal advance.

Optional Feature:
- Macro FWD_WB_BYPASS_EN.
- Defined: adds outputs id_byp_a_o and id_byp_b_o (1 bit each).
  - id_byp_a_o = wb_we and wb_rd!=0 and wb_rd==id_rs1_i; id_byp_b_o likewise with id_rs2_i.
  - Drives the register-file write-through bypass into ID.
- Undefined: ports absent. The register file must write in the first half-cycle.

Decomposition:
- Shared package cpu_pkg:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_AW default.
  - Struct typedef for a pipeline tracking slot {rd, we, mr}.
- One natural sub-module: fwd_sel. Purely combinational; maps (ex_rs, mem slot, wb slot) to a 2-bit select. Instantiated twice, once for A and once for B.

Test Plan:
- Consecutive ALU ops write/read x5 (add x5; sub x6,x5,x1): the cycle the sub is in EX gives fwd_a_o=2'b10. One gap instruction instead gives 2'b01.
- Load x7, then next instruction reads x7 in rs2: stall_o=1 and pc_write_o=0 for exactly one cycle, then EX holds a bubble. Next cycle fwd_b_o=2'b01 and stall_cnt_o=1.
- rd=x0 ALU op followed by a reader of x0: fwd_*=2'b00 and stall_o=0. A load to x0 followed by a reader gives no stall.
- Same rd=x3 in both MEM and WB, EX reads x3 on both operands: fwd_a_o=fwd_b_o=2'b10.
- mem_stall_i high for 4 cycles during a load-use hazard: slots and selects frozen, stall_cnt_o unchanged. On release, one counted stall cycle.
- Force the counter to 16'hFFFE and create 3 hazards: counter ends at 16'hFFFF. Then pulse rst_i low mid-run: all outputs return to reset values immediately.
